otter_csr_unit: RTL and testbench
=================================

# otter_csr_unit

Machine-mode CSR and interrupt-control unit for the OTTER multicycle MCU. It is the responder to the control decoder's CSR, MRET and interrupt signalling. It holds mstatus, mtvec, mepc and mcause, latches the external interrupt and raises a request to the control FSM. It updates trap state when the FSM asserts `int_taken` or executes MRET. Its `mtvec`/`mepc` outputs feed the PC source mux inputs 4 and 5.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on `intr_in` (valid values 2–3).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `intr_in` in 1: external interrupt, asynchronous level.
- `csr_we` in 1: one-cycle CSR write strobe, asserted by the FSM in writeback.
- `csr_addr` in 12: CSR address, instr[31:20].
- `csr_wd` in 32: write data (ALU result).
- `pc` in 32: PC of the instruction being interrupted.
- `int_taken` in 1: one-cycle trap-entry strobe from the FSM.
- `mret_exec` in 1: one-cycle MRET strobe from the FSM.
- `csr_rd` out 32: read data for `csr_addr`, combinational.
- `mtvec` out 32: trap vector, bits[1:0] always 0.
- `mepc` out 32: return address, bits[1:0] always 0.
- `mie` out 1: mstatus.MIE.
- `int_req` out 1: pending interrupt AND MIE, registered.

## Operation
- Implemented CSRs:
  - mstatus 0x300: only bit 3 (MIE) and bit 7 (MPIE) are stored; other bits read 0.
  - mtvec 0x305.
  - mepc 0x341.
  - mcause 0x342.
- Unimplemented addresses read 0; writes to them are ignored.
- Write masking:
  - mtvec and mepc: bits[1:0] are forced to 0 on write.
  - mcause: all 32 bits are writable.
- Interrupt capture:
  - `intr_in` passes through `SYNC_STAGES` flops.
  - A 0→1 edge on the synchronized signal sets `pending`.
  - `int_taken` clears `pending`.
  - If a new edge and `int_taken` occur in the same cycle, `pending` stays set (the edge wins).
- `int_req` register is loaded each cycle with `pending & MIE`.
- Trap entry (`int_taken`=1):
  - mepc ← {pc[31:2],2'b00}
  - mcause ← 32'h8000_000B
  - MPIE ← MIE
  - MIE ← 0
- MRET (`mret_exec`=1): MIE ← MPIE; MPIE ← 1.
- Priority for same-cycle strobes, highest first: `int_taken` > `mret_exec` > `csr_we`. A lower-priority update is fully dropped, including any CSR write to unrelated registers.
- CSR writes carry no set/clear semantics in this block; set/clear is resolved upstream by the ALU.

## Timing
- Reset: all CSRs = 0, `pending` = 0, sync flops = 0, `int_req` = 0. Therefore `mtvec`=0, `mepc`=0, `mie`=0, and `csr_rd`=0 for any address.
- Writes are visible on `csr_rd`, `mtvec`, `mepc` and `mie` in the cycle after the strobe edge.
- Interrupt latency:
  - A synchronized edge sets `pending` at sync edge + 1 cycle.
  - `int_req` rises one cycle after that.
  - Total from `intr_in` rise to `int_req`=1: `SYNC_STAGES`+2 edges, given MIE=1.
- `int_req` falls the cycle after `int_taken`, because both `pending` and MIE clear.
- A level held high on `intr_in` does not retrigger; a new 0→1 edge is required.
- An interrupt arriving while MIE=0 stays pending. `int_req` asserts one cycle after MIE is set by a CSR write or by MRET.
- `rst` overrides every strobe in the same cycle.

## Configuration
- `OTTER_CSR_MCYCLE_EN` defined:
  - Adds a 64-bit cycle counter, readable at mcycle 0xB00 (low word) and mcycleh 0xB80 (high word).
  - Counter increments by 1 every cycle and wraps from 2^64−1 to 0.
  - A write loads the addressed half with `csr_wd` and suppresses the increment for that cycle. The other half is held, so no carry propagates into it that cycle.
  - Reset value is 0.
- `OTTER_CSR_MCYCLE_EN` undefined: no counter logic; 0xB00 and 0xB80 read 0 and ignore writes.

## Test plan
- Reset, then read 0x300/0x305/0x341/0x342 → all 0; `int_req`=0.
- Write 0x305 ← 32'h0000_0103 → `mtvec`=32'h0000_0100 next cycle. Write 0x300 ← 32'hFFFF_FFFF → `csr_rd` at 0x300 = 32'h0000_0088 and `mie`=1.
- MIE=1, pulse `intr_in` → `int_req`=1 after 4 edges (`SYNC_STAGES`=2). Then `int_taken` with pc=32'h0000_0206 → mepc=32'h0000_0204, mcause=32'h8000_000B, MIE=0, MPIE=1, and `int_req`=0 next cycle.
- After that trap, pulse `mret_exec` → MIE=1, MPIE=1. An `intr_in` edge during the trap handler while MIE=0 → `int_req`=1 one cycle after the MRET.
- Same cycle: `int_taken`, `mret_exec`, and `csr_we` to 0x341 ← 32'hDEAD_BEEF → mepc equals the trapped pc (not 32'hDEAD_BEEF) and MIE=0.
- With `OTTER_CSR_MCYCLE_EN`: write 0xB00 ← 32'hFFFF_FFFE, then wait 3 cycles → 0xB80 reads 1 and 0xB00 reads 1. Without the macro, 0xB00 always reads 0.

Source files
------------

// File: rtl/otter_csr_if.sv
// rtl/otter_csr_if.sv - CSR/trap signalling between the OTTER control FSM and otter_csr_unit
//
// master : control FSM side (drives strobes, address, write data, pc)
// slave  : otter_csr_unit side (drives csr_rd, mtvec, mepc, mie, int_req)
//   csr_we     1   CSR write strobe (writeback)
//   csr_addr   12  CSR address, instr[31:20]
//   csr_wd     32  CSR write data (ALU result)
//   pc         32  PC of the instruction being interrupted
//   int_taken  1   trap-entry strobe
//   mret_exec  1   MRET strobe
//   csr_rd     32  combinational read data for csr_addr
//   mtvec      32  trap vector (PC mux input 4)
//   mepc       32  return address (PC mux input 5)
//   mie        1   mstatus.MIE
//   int_req    1   registered interrupt request to the FSM

interface otter_csr_if;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wd;
    logic [31:0] pc;
    logic        int_taken;
    logic        mret_exec;
    logic [31:0] csr_rd;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        mie;
    logic        int_req;

    modport master (
        output csr_we, csr_addr, csr_wd, pc, int_taken, mret_exec,
        input  csr_rd, mtvec, mepc, mie, int_req
    );

    modport slave (
        input  csr_we, csr_addr, csr_wd, pc, int_taken, mret_exec,
        output csr_rd, mtvec, mepc, mie, int_req
    );
endinterface

// File: rtl/otter_csr_unit.sv
// rtl/otter_csr_unit.sv - machine-mode CSRs and interrupt control for the OTTER multicycle MCU
//
// Parameter SYNC_STAGES (2..3): synchronizer depth on intr_in.
// Optional feature macro OTTER_CSR_MCYCLE_EN: 64-bit mcycle/mcycleh counter at 0xB00/0xB80.
// Ports:
//   clk      single clock, rising edge
//   rst      synchronous active-high reset
//   intr_in  asynchronous external interrupt level
//   bus      otter_csr_if.slave (strobes in; csr_rd, mtvec, mepc, mie, int_req out)

module otter_csr_unit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        intr_in,
    otter_csr_if.slave  bus
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
`ifdef OTTER_CSR_MCYCLE_EN
    localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;
`endif
    localparam logic [31:0] CAUSE_EXT_INT = 32'h8000_000B;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   sync_rise;
    logic                   pending;
    logic                   int_req_q;
    logic                   mie_q;
    logic                   mpie_q;
    logic [31:0]            mtvec_q;
    logic [31:0]            mepc_q;
    logic [31:0]            mcause_q;
    logic                   do_mret;
    logic                   do_write;
    logic [31:0]            csr_rd_c;

    // Strobe priority: a trap swallows MRET and CSR writes; MRET swallows CSR writes.
    assign do_mret  = bus.mret_exec & ~bus.int_taken;
    assign do_write = bus.csr_we & ~bus.int_taken & ~bus.mret_exec;

    assign sync_rise = sync_q[SYNC_STAGES-1] & ~sync_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
            pending   <= 1'b0;
            int_req_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], intr_in};
            sync_prev <= sync_q[SYNC_STAGES-1];
            // A fresh edge beats a same-cycle trap so that interrupt is not lost.
            if (sync_rise)
                pending <= 1'b1;
            else if (bus.int_taken)
                pending <= 1'b0;
            int_req_q <= pending & mie_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mtvec_q  <= '0;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else if (bus.int_taken) begin
            mepc_q   <= bus.pc & 32'hFFFF_FFFC;
            mcause_q <= CAUSE_EXT_INT;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (do_mret) begin
            mie_q    <= mpie_q;
            mpie_q   <= 1'b1;
        end else if (do_write) begin
            case (bus.csr_addr)
                ADDR_MSTATUS: begin
                    mie_q  <= bus.csr_wd[3];
                    mpie_q <= bus.csr_wd[7];
                end
                ADDR_MTVEC:  mtvec_q  <= bus.csr_wd & 32'hFFFF_FFFC;
                ADDR_MEPC:   mepc_q   <= bus.csr_wd & 32'hFFFF_FFFC;
                ADDR_MCAUSE: mcause_q <= bus.csr_wd;
                default: ;
            endcase
        end
    end

`ifdef OTTER_CSR_MCYCLE_EN
    logic [63:0] mcycle_q;

    // A write to one half freezes the whole counter for that cycle, so the
    // untouched half never sees a carry out of the written half.
    always_ff @(posedge clk) begin
        if (rst)
            mcycle_q <= '0;
        else if (do_write && bus.csr_addr == ADDR_MCYCLE)
            mcycle_q[31:0] <= bus.csr_wd;
        else if (do_write && bus.csr_addr == ADDR_MCYCLEH)
            mcycle_q[63:32] <= bus.csr_wd;
        else
            mcycle_q <= mcycle_q + 64'd1;
    end
`endif

    always_comb begin
        csr_rd_c = '0;
        case (bus.csr_addr)
            ADDR_MSTATUS: csr_rd_c = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};
            ADDR_MTVEC:   csr_rd_c = mtvec_q;
            ADDR_MEPC:    csr_rd_c = mepc_q;
            ADDR_MCAUSE:  csr_rd_c = mcause_q;
`ifdef OTTER_CSR_MCYCLE_EN
            ADDR_MCYCLE:  csr_rd_c = mcycle_q[31:0];
            ADDR_MCYCLEH: csr_rd_c = mcycle_q[63:32];
`endif
            default: ;
        endcase
    end

    assign bus.csr_rd  = csr_rd_c;
    assign bus.mtvec   = mtvec_q;
    assign bus.mepc    = mepc_q;
    assign bus.mie     = mie_q;
    assign bus.int_req = int_req_q;

endmodule

// File: tb/tb_otter_csr_unit.sv
// tb/tb_otter_csr_unit.sv - scoreboard testbench for otter_csr_unit

module tb_otter_csr_unit;

    localparam int S = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic intr_in = 1'b0;
    logic intr_lvl = 1'b0;

    always #5 clk = ~clk;

    otter_csr_if bus ();

    otter_csr_unit #(.SYNC_STAGES(S)) dut (
        .clk     (clk),
        .rst     (rst),
        .intr_in (intr_in),
        .bus     (bus)
    );

    typedef struct {
        logic [11:0] addr;
        logic [31:0] rd;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        mie;
        logic        int_req;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_valid = 0;
    logic        m_mie, m_mpie, m_pending, m_int_req;
    logic [31:0] m_mtvec, m_mepc, m_mcause;
    logic [63:0] m_cycle;
    logic        m_hist[$];   // intr_in samples, newest first

    function automatic logic [31:0] m_read(input logic [11:0] a);
        logic [31:0] v;
        v = 32'h0;
        if (a == 12'h300) begin
            v[3] = m_mie;
            v[7] = m_mpie;
        end
        else if (a == 12'h305) v = m_mtvec;
        else if (a == 12'h341) v = m_mepc;
        else if (a == 12'h342) v = m_mcause;
`ifdef OTTER_CSR_MCYCLE_EN
        else if (a == 12'hB00) v = m_cycle[31:0];
        else if (a == 12'hB80) v = m_cycle[63:32];
`endif
        return v;
    endfunction

    task automatic model_update(input logic r, input logic i, input logic we,
                                input logic [11:0] a, input logic [31:0] wd,
                                input logic [31:0] pcv, input logic it, input logic mr);
        logic rise;
        logic wr_ok;
        if (r) begin
            m_valid = 1;
            m_mie = 0; m_mpie = 0; m_pending = 0; m_int_req = 0;
            m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_cycle = 0;
            m_hist.delete();
            for (int k = 0; k <= S; k++) m_hist.push_back(1'b0);
            return;
        end
        // Synchronized input after this edge is the sample from S-1 edges ago;
        // a rise seen now is the difference between the samples S and S+1 edges back.
        rise = m_hist[S-1] & ~m_hist[S];
        m_hist.push_front(i);
        void'(m_hist.pop_back());
        m_int_req = m_pending & m_mie;
        if (rise) m_pending = 1;
        else if (it) m_pending = 0;
        wr_ok = we && !it && !mr;
`ifdef OTTER_CSR_MCYCLE_EN
        if (wr_ok && a == 12'hB00) m_cycle = {m_cycle[63:32], wd};
        else if (wr_ok && a == 12'hB80) m_cycle = {wd, m_cycle[31:0]};
        else m_cycle = m_cycle + 1;
`endif
        if (it) begin
            m_mepc = {pcv[31:2], 2'b00};
            m_mcause = 32'h8000_000B;
            m_mpie = m_mie;
            m_mie = 0;
        end else if (mr) begin
            m_mie = m_mpie;
            m_mpie = 1;
        end else if (wr_ok) begin
            if (a == 12'h300) begin m_mie = wd[3]; m_mpie = wd[7]; end
            else if (a == 12'h305) m_mtvec = {wd[31:2], 2'b00};
            else if (a == 12'h341) m_mepc = {wd[31:2], 2'b00};
            else if (a == 12'h342) m_mcause = wd;
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected while they are held,
    // then advance the model across the clock edge.
    task automatic cycle(input logic r, input logic we, input logic [11:0] a,
                         input logic [31:0] wd, input logic [31:0] pcv,
                         input logic it, input logic mr);
        exp_t x;
        rst = r; intr_in = intr_lvl;
        bus.csr_we = we; bus.csr_addr = a; bus.csr_wd = wd;
        bus.pc = pcv; bus.int_taken = it; bus.mret_exec = mr;
        if (m_valid) begin
            x.addr = a; x.rd = m_read(a); x.mtvec = m_mtvec; x.mepc = m_mepc;
            x.mie = m_mie; x.int_req = m_int_req;
            sb.push_back(x);
        end
        @(posedge clk);
        model_update(r, intr_lvl, we, a, wd, pcv, it, mr);
        #1;
    endtask

    task automatic rd(input logic [11:0] a);
        cycle(0, 0, a, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        cycle(0, 1, a, d, 32'h0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [11:0] a,
                       input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s addr=%h actual=%h required=%h at %0t", name, a, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("csr_rd",  e.addr, bus.csr_rd, e.rd);
            chk("mtvec",   e.addr, bus.mtvec, e.mtvec);
            chk("mepc",    e.addr, bus.mepc, e.mepc);
            chk("mie",     e.addr, {31'h0, bus.mie}, {31'h0, e.mie});
            chk("int_req", e.addr, {31'h0, bus.int_req}, {31'h0, e.int_req});
        end
    end

    logic [11:0] addrs [8];

    initial begin
        addrs = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hB00, 12'hB80, 12'h123, 12'h000};
        bus.csr_we = 0; bus.csr_addr = 0; bus.csr_wd = 0;
        bus.pc = 0; bus.int_taken = 0; bus.mret_exec = 0;
        #1;
        cycle(1, 0, 12'h300, 0, 0, 0, 0);
        cycle(1, 0, 12'h300, 0, 0, 0, 0);
        foreach (addrs[k]) rd(addrs[k]);

        wr(12'h305, 32'h0000_0103);
        rd(12'h305);
        wr(12'h300, 32'hFFFF_FFFF);
        rd(12'h300);

        intr_lvl = 1;
        repeat (5) rd(12'h300);
        intr_lvl = 0;
        repeat (2) rd(12'h300);

        cycle(0, 0, 12'h341, 0, 32'h0000_0206, 1, 0);
        rd(12'h341); rd(12'h342); rd(12'h300);

        intr_lvl = 1;
        repeat (4) rd(12'h300);
        intr_lvl = 0;
        repeat (2) rd(12'h300);
        cycle(0, 0, 12'h300, 0, 0, 0, 1);
        repeat (3) rd(12'h300);

        cycle(0, 1, 12'h341, 32'hDEAD_BEEF, 32'h0000_1238, 1, 1);
        rd(12'h341); rd(12'h300);

        wr(12'h123, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFE);
        rd(12'hB00); rd(12'hB80); rd(12'hB00); rd(12'hB80);
        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFF);
        rd(12'hB00); rd(12'hB80); rd(12'hB00);

        cycle(1, 1, 12'h305, 32'h1234_5678, 32'h44, 1, 1);
        foreach (addrs[k]) rd(addrs[k]);

        for (int n = 0; n < 800; n++) begin
            logic        r, we, it, mr;
            logic [31:0] wd;
            if ($urandom_range(0, 7) == 0) intr_lvl = ~intr_lvl;
            r  = ($urandom_range(0, 199) == 0);
            we = ($urandom_range(0, 3) == 0);
            it = ($urandom_range(0, 9) == 0);
            mr = ($urandom_range(0, 9) == 0);
            wd = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            cycle(r, we, addrs[$urandom_range(0, 7)], wd, $urandom, it, mr);
        end

        rd(12'h300);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
